// File: rtl/sound_req_ctrl_if.sv
// Request/selection bundle between the payment/BGM host and the sound request sequencer.
interface sound_req_ctrl_if;
    logic       bgm_on;
    logic       bgm_track;
    logic       mute;
    logic       pay_ok;
    logic       pay_fail;
    logic [2:0] music_sel;
    logic       music_en;
    logic       busy;
    logic       jingle_done;

    // Host side: raises requests, observes the player selection.
    modport master (
        output bgm_on,
        output bgm_track,
        output mute,
        output pay_ok,
        output pay_fail,
        input  music_sel,
        input  music_en,
        input  busy,
        input  jingle_done
    );

    // Sequencer side.
    modport slave (
        input  bgm_on,
        input  bgm_track,
        input  mute,
        input  pay_ok,
        input  pay_fail,
        output music_sel,
        output music_en,
        output busy,
        output jingle_done
    );
endinterface

// File: rtl/sound_req_ctrl.sv
// Sequencer in front of the buzzer player: arbitrates background music against payment
// jingles, inserts a silent gap before each new selection and times jingles in beats.
module sound_req_ctrl #(
    parameter int unsigned BEAT_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned OK_BEATS    = 4,
    parameter int unsigned FAIL_BEATS  = 3
) (
    input  logic            clk,
    input  logic            rst,
    sound_req_ctrl_if.slave bus
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGap    = 2'd1;
    localparam logic [1:0] StBgm    = 2'd2;
    localparam logic [1:0] StJingle = 2'd3;

    localparam logic [2:0] SelNone = 3'd0;
    localparam logic [2:0] SelOk   = 3'd3;
    localparam logic [2:0] SelFail = 3'd4;

    localparam logic [25:0]     BeatLast = 26'(BEAT_CYCLES - 1);
    localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYCLES - 1);
    localparam logic [3:0]      OkLast   = 4'(OK_BEATS - 1);
    localparam logic [3:0]      FailLast = 4'(FAIL_BEATS - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      tgt_q, tgt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [25:0]     cyc_cnt_q, cyc_cnt_d;
    logic [3:0]      beat_cnt_q, beat_cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic       ev_fail, ev_ok, bgm_want, restart, tgt_is_bgm, expired;
    logic [2:0] bgm_sel;
    logic [3:0] beat_last;

    assign ev_fail    = bus.pay_fail;
    assign ev_ok      = bus.pay_ok & ~bus.pay_fail;
    assign bgm_want   = bus.bgm_on & ~bus.mute;
    assign bgm_sel    = 3'd1 + {2'b00, bus.bgm_track};
    assign tgt_is_bgm = (tgt_q == 3'd1) || (tgt_q == 3'd2);
    assign beat_last  = (tgt_q == SelFail) ? FailLast : OkLast;
    assign expired    = (beat_cnt_q == beat_last) && (cyc_cnt_q == BeatLast);

    // Next-state, target and counter update; every state (re)entry clears the counters.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        gap_cnt_d  = gap_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        restart    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ev_fail) begin
                    state_d = StGap; tgt_d = SelFail; restart = 1'b1;
                end else if (ev_ok) begin
                    state_d = StGap; tgt_d = SelOk; restart = 1'b1;
                end else if (bgm_want) begin
                    state_d = StGap; tgt_d = bgm_sel; restart = 1'b1;
                end
            end
            StGap: begin
                if (ev_fail) begin
                    tgt_d = SelFail; restart = 1'b1;
                end else if (ev_ok && (tgt_q != SelFail)) begin
                    tgt_d = SelOk; restart = 1'b1;
                end else if (tgt_is_bgm && !bgm_want) begin
                    state_d = StIdle; tgt_d = SelNone; restart = 1'b1;
                end else if (tgt_is_bgm && (bgm_sel != tgt_q)) begin
                    // Track flipped while still silent: re-gap towards the new track.
                    tgt_d = bgm_sel; restart = 1'b1;
                end else if (gap_cnt_q == GapLast) begin
                    state_d = tgt_is_bgm ? StBgm : StJingle; restart = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StBgm: begin
                if (ev_fail) begin
                    state_d = StGap; tgt_d = SelFail; restart = 1'b1;
                end else if (ev_ok) begin
                    state_d = StGap; tgt_d = SelOk; restart = 1'b1;
                end else if (!bgm_want) begin
                    state_d = StIdle; tgt_d = SelNone; restart = 1'b1;
                end else if (bgm_sel != tgt_q) begin
                    state_d = StGap; tgt_d = bgm_sel; restart = 1'b1;
                end
            end
            StJingle: begin
                // A pre-empting event wins over expiry, so no done pulse in that case.
                if (ev_fail) begin
                    state_d = StGap; tgt_d = SelFail; restart = 1'b1;
                end else if (ev_ok && (tgt_q == SelOk)) begin
                    state_d = StGap; tgt_d = SelOk; restart = 1'b1;
                end else if (expired) begin
                    done_d  = 1'b1;
                    restart = 1'b1;
                    if (bgm_want) begin
                        state_d = StGap; tgt_d = bgm_sel;
                    end else begin
                        state_d = StIdle; tgt_d = SelNone;
                    end
                end else if (cyc_cnt_q == BeatLast) begin
                    cyc_cnt_d  = '0;
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 26'd1;
                end
            end
            default: begin
                state_d = StIdle; tgt_d = SelNone; restart = 1'b1;
            end
        endcase

        if (restart) begin
            gap_cnt_d  = '0;
            cyc_cnt_d  = '0;
            beat_cnt_d = '0;
        end
    end

    // Registered outputs derived from the upcoming state so they change with it.
    always_comb begin
        sel_d  = (state_d == StIdle) ? SelNone : tgt_d;
        en_d   = ((state_d == StBgm) || (state_d == StJingle)) && !bus.mute;
        busy_d = (state_d == StJingle) || ((state_d == StGap) && (tgt_d >= SelOk));
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tgt_q      <= SelNone;
            gap_cnt_q  <= '0;
            cyc_cnt_q  <= '0;
            beat_cnt_q <= '0;
            sel_q      <= SelNone;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            gap_cnt_q  <= gap_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.music_sel   = sel_q;
    assign bus.music_en    = en_q;
    assign bus.busy        = busy_q;
    assign bus.jingle_done = done_q;

endmodule

// File: tb/tb_sound_req_ctrl.sv
// Bench for sound_req_ctrl: directed test-plan scenarios plus random traffic, all checked
// against a mode/elapsed-time reference model.
module tb_sound_req_ctrl;

    localparam int unsigned Beat = 10;
    localparam int unsigned Gap  = 4;
    localparam int unsigned OkB  = 3;
    localparam int unsigned FailB = 2;

    localparam int MIdle = 0;
    localparam int MGap  = 1;
    localparam int MBgm  = 2;
    localparam int MJing = 3;

    logic clk;
    logic rst;

    sound_req_ctrl_if bus();

    sound_req_ctrl #(
        .BEAT_CYCLES (Beat),
        .GAP_CYCLES  (Gap),
        .OK_BEATS    (OkB),
        .FAIL_BEATS  (FailB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what is playing, toward what, and for how long.
    int m_mode = MIdle;
    int m_tgt  = 0;
    int m_t    = 0;
    bit m_en   = 0;
    bit m_done = 0;

    // Observation counters.
    int jd_cnt   = 0;
    int run      = 0;
    int last_run = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic go(input int m, input int tg);
        m_mode = m;
        m_tgt  = tg;
        m_t    = 0;
    endtask

    task automatic model_step();
        bit fail_e, ok_e, want;
        int bsel, dur;
        m_done = 0;
        if (rst) begin
            go(MIdle, 0);
        end else begin
            fail_e = bus.pay_fail;
            ok_e   = bus.pay_ok && !bus.pay_fail;
            want   = bus.bgm_on && !bus.mute;
            bsel   = bus.bgm_track ? 2 : 1;
            if (m_mode == MIdle) begin
                if (fail_e) go(MGap, 4);
                else if (ok_e) go(MGap, 3);
                else if (want) go(MGap, bsel);
            end else if (m_mode == MGap) begin
                if (fail_e) go(MGap, 4);
                else if (ok_e && m_tgt != 4) go(MGap, 3);
                else if (m_tgt < 3 && !want) go(MIdle, 0);
                else if (m_tgt < 3 && bsel != m_tgt) go(MGap, bsel);
                else if (m_t + 1 == Gap) go((m_tgt >= 3) ? MJing : MBgm, m_tgt);
                else m_t++;
            end else if (m_mode == MBgm) begin
                if (fail_e) go(MGap, 4);
                else if (ok_e) go(MGap, 3);
                else if (!want) go(MIdle, 0);
                else if (bsel != m_tgt) go(MGap, bsel);
            end else begin
                dur = ((m_tgt == 4) ? FailB : OkB) * Beat;
                if (fail_e) go(MGap, 4);
                else if (ok_e && m_tgt == 3) go(MGap, 3);
                else if (m_t + 1 == dur) begin
                    m_done = 1;
                    if (want) go(MGap, bsel);
                    else go(MIdle, 0);
                end else m_t++;
            end
        end
        m_en = !rst && (m_mode == MBgm || m_mode == MJing) && !bus.mute;
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("sel",  int'(bus.music_sel), (m_mode == MIdle) ? 0 : m_tgt);
        chk("en",   int'(bus.music_en), int'(m_en));
        chk("busy", int'(bus.busy),
            int'(m_mode == MJing || (m_mode == MGap && m_tgt >= 3)));
        chk("done", int'(bus.jingle_done), int'(m_done));
        if (bus.jingle_done) jd_cnt++;
        if (bus.music_en && bus.music_sel >= 3) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_ok();
        bus.pay_ok = 1'b1; cyc(); bus.pay_ok = 1'b0;
    endtask

    task automatic pulse_fail();
        bus.pay_fail = 1'b1; cyc(); bus.pay_fail = 1'b0;
    endtask

    int jd0;

    initial begin
        rst = 1'b1;
        bus.bgm_on = 1'b0; bus.bgm_track = 1'b0; bus.mute = 1'b0;
        bus.pay_ok = 1'b0; bus.pay_fail = 1'b0;
        cycles(2);
        chk("rst_sel", int'(bus.music_sel), 0);
        chk("rst_en", int'(bus.music_en), 0);
        rst = 1'b0;
        cycles(2);

        // BGM start: 4 silent cycles, then track 1 enabled.
        bus.bgm_on = 1'b1;
        cycles(10);
        chk("bgm_sel", int'(bus.music_sel), 1);
        chk("bgm_en", int'(bus.music_en), 1);

        // Ok jingle from BGM, then back to BGM.
        jd0 = jd_cnt;
        pulse_ok();
        cycles(45);
        chk("ok_len", last_run, 30);
        chk("ok_done", jd_cnt - jd0, 1);
        chk("ok_resume", int'(bus.music_sel), 1);

        // Simultaneous ok+fail from IDLE is a fail jingle; ok during it is ignored.
        bus.bgm_on = 1'b0;
        cycles(3);
        jd0 = jd_cnt;
        bus.pay_ok = 1'b1; bus.pay_fail = 1'b1; cyc();
        bus.pay_ok = 1'b0; bus.pay_fail = 1'b0;
        cycles(8);
        pulse_ok();
        cycles(25);
        chk("fail_len", last_run, 20);
        chk("fail_done", jd_cnt - jd0, 1);

        // Fail pre-empts an ok jingle at cycle 12; only the fail jingle completes.
        jd0 = jd_cnt;
        pulse_ok();
        cycles(15);
        pulse_fail();
        cycles(30);
        chk("pre_len", last_run, 20);
        chk("pre_done", jd_cnt - jd0, 1);
        chk("pre_idle", int'(bus.music_sel), 0);

        // Mute during ok jingle: timing continues, then IDLE.
        bus.bgm_on = 1'b1;
        cycles(8);
        jd0 = jd_cnt;
        pulse_ok();
        cycles(14);
        bus.mute = 1'b1;
        cycles(25);
        chk("mute_done", jd_cnt - jd0, 1);
        chk("mute_idle", int'(bus.music_sel), 0);
        bus.mute = 1'b0;
        cycles(8);
        bus.mute = 1'b1;
        cycles(3);
        chk("mute_bgm_idle", int'(bus.music_sel), 0);
        bus.mute = 1'b0;

        // Reset mid-GAP and mid-JINGLE.
        jd0 = jd_cnt;
        pulse_ok();
        cycles(2);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_gap_busy", int'(bus.busy), 0);
        cycles(6);
        pulse_fail();
        cycles(10);
        rst = 1'b1; bus.pay_fail = 1'b1; cyc(); rst = 1'b0; bus.pay_fail = 1'b0;
        chk("rst_jing_en", int'(bus.music_en), 0);
        chk("rst_no_done", jd_cnt - jd0, 0);
        cycles(5);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.bgm_on = ~bus.bgm_on;
            if ($urandom_range(0, 59) == 0) bus.bgm_track = ~bus.bgm_track;
            if ($urandom_range(0, 79) == 0) bus.mute = ~bus.mute;
            bus.pay_ok   = ($urandom_range(0, 24) == 0);
            bus.pay_fail = ($urandom_range(0, 49) == 0);
            rst          = ($urandom_range(0, 599) == 0);
            cyc();
        end
        rst = 1'b0; bus.pay_ok = 1'b0; bus.pay_fail = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
